reduced_word_packetizer: RTL

- Sits directly downstream of the async 128->64 bit-width reducer, in its RD_CLK domain.
- Accepts the reducer's 64-bit DOUT/CONVERT_VALID word stream and drives the reducer's MODULE_READY.
- Buffers words and emits AXI4-Stream packets of fixed length, with TLAST.
- Closes a partially filled packet with an all-ones pad word after an idle timeout.

---
 rtl/reduced_word_packetizer_pkg.sv | 28 ++
 rtl/reduced_word_packetizer_if.sv | 34 +++
 rtl/reduced_word_packetizer_sync_fifo_fwft.sv | 52 +++++
 rtl/reduced_word_packetizer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/reduced_word_packetizer_pkg.sv
// Shared definitions for the reduced-word packetizer and its integration
// with the 128->64 bit-width reducer.
//   clogb2        : ceil(log2(value)); clogb2(1) = 0
//   state_t       : packetizer FSM encoding (IDLE/BODY/PAD)
//   PAD_WORD      : all-ones word used to close a timed-out packet
//   DEFAULT_*     : defaults shared with the reducer integration
package reduced_word_packetizer_pkg;

  localparam int DEFAULT_DATA_WIDTH   = 64;
  localparam int DEFAULT_PACKET_WORDS = 32;
  localparam int DEFAULT_HEADROOM     = 8;

  localparam logic [DEFAULT_DATA_WIDTH-1:0] PAD_WORD = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BODY = 2'd1,
    PAD  = 2'd2
  } state_t;

  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/reduced_word_packetizer_if.sv
// Word-in / AXI4-Stream-out bundle of the packetizer.
//   DIN, DIN_VALID     : reducer word stream (no per-word backpressure)
//   MODULE_READY       : registered flow-control hint back to the reducer
//   M_AXIS_*           : packet stream; a beat transfers when TVALID && TREADY
//                        on a rising edge, and TDATA/TLAST hold while
//                        TVALID=1 and TREADY=0
//   OVERFLOW           : sticky word-dropped flag
//   state              : packetizer FSM state, for observation
// slave is the packetizer side; master is the environment (reducer + sink).
interface reduced_word_packetizer_if
  import reduced_word_packetizer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] DIN;
  logic                  DIN_VALID;
  logic                  MODULE_READY;
  logic [DATA_WIDTH-1:0] M_AXIS_TDATA;
  logic                  M_AXIS_TVALID;
  logic                  M_AXIS_TREADY;
  logic                  M_AXIS_TLAST;
  logic                  OVERFLOW;
  state_t                state;

  modport slave (
    input  DIN, DIN_VALID, M_AXIS_TREADY,
    output MODULE_READY, M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST, OVERFLOW, state
  );

  modport master (
    output DIN, DIN_VALID, M_AXIS_TREADY,
    input  MODULE_READY, M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST, OVERFLOW, state
  );
endinterface

// File: rtl/reduced_word_packetizer_sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO.
//   clk, rst_n        : clock, asynchronous active-low reset
//   wr_en, wr_data    : write request (ignored while full)
//   rd_en             : pop the head (ignored while empty)
//   rd_data           : current head word, valid while not_empty
//   not_empty, full   : occupancy flags
//   free              : number of free entries
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo_fwft
  import reduced_word_packetizer_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   not_empty,
  output logic                   full,
  output logic [clogb2(DEPTH):0] free
);
  localparam int AW = clogb2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      used;

  assign used      = wr_ptr - rd_ptr;
  assign not_empty = (used != '0);
  assign full      = (used == PW'(DEPTH));
  assign free      = PW'(DEPTH) - used;
  assign rd_data   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full)    wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && not_empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/reduced_word_packetizer.sv
// Packs the reducer's word stream into fixed-length AXI4-Stream packets.
//   CLK, RESETN : reducer RD_CLK, asynchronous active-low reset
//   bus         : reduced_word_packetizer_if.slave (word input, MODULE_READY,
//                 M_AXIS stream, OVERFLOW, FSM state)
// Path: input register -> FWFT FIFO -> output register. An open packet that
// sees no traffic for TIMEOUT_CYCLES is closed by an all-ones pad beat.
module reduced_word_packetizer
  import reduced_word_packetizer_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int PACKET_WORDS   = DEFAULT_PACKET_WORDS,
  parameter int FIFO_DEPTH     = 16,
  parameter int HEADROOM       = DEFAULT_HEADROOM,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int DROP_ALL_ONES  = 1
) (
  input logic                      CLK,
  input logic                      RESETN,
  reduced_word_packetizer_if.slave bus
);
  localparam int CW     = clogb2(PACKET_WORDS);
  localparam int FREE_W = clogb2(FIFO_DEPTH) + 1;
  localparam int TW     = (TIMEOUT_CYCLES < 1) ? 1 : clogb2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0]     CNT_LAST  = CW'(PACKET_WORDS - 1);
  localparam logic [TW-1:0]     TIMER_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [FREE_W-1:0] HR_V      = FREE_W'(HEADROOM);
  localparam logic [FREE_W-1:0] HR_PLUS1  = FREE_W'(HEADROOM + 1);

  // input stage
  logic                  in_valid_q;
  logic [DATA_WIDTH-1:0] in_data_q;
  logic                  in_word;
  logic                  overflow_q;
  logic                  ready_q;

  // FIFO
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_not_empty;
  logic                  fifo_full;
  logic [FREE_W-1:0]     fifo_free;
  logic                  fifo_wr;
  logic                  fifo_rd;

  // packetizer
  state_t                state, state_next;
  logic [TW-1:0]         timer, timer_next;
  logic [CW-1:0]         count, count_next;
  logic                  out_valid, out_valid_next;
  logic [DATA_WIDTH-1:0] out_data, out_data_next;
  logic                  out_pad, out_pad_next;
  logic                  out_last;
  logic                  beat;
  logic                  idle_cond;

  // Filler words from the reducer are treated as if nothing arrived.
  assign in_word = in_valid_q && !((DROP_ALL_ONES != 0) && (in_data_q == '1));
  assign fifo_wr = in_word && !fifo_full;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      in_valid_q <= 1'b0;
      in_data_q  <= '0;
      overflow_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      in_valid_q <= bus.DIN_VALID;
      in_data_q  <= bus.DIN;
      if (in_word && fifo_full) overflow_q <= 1'b1;
      // The word sitting in the input register already owns one free entry.
      ready_q <= in_word ? (fifo_free > HR_PLUS1) : (fifo_free > HR_V);
    end
  end

  sync_fifo_fwft #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RESETN),
    .wr_en     (fifo_wr),
    .wr_data   (in_data_q),
    .rd_en     (fifo_rd),
    .rd_data   (fifo_data),
    .not_empty (fifo_not_empty),
    .full      (fifo_full),
    .free      (fifo_free)
  );

  assign beat      = out_valid && bus.M_AXIS_TREADY;
  assign out_last  = out_valid && (out_pad || (count == CNT_LAST));
  assign idle_cond = !fifo_not_empty && !out_valid && !in_word;

  always_comb begin
    state_next     = state;
    timer_next     = timer;
    count_next     = count;
    out_valid_next = out_valid;
    out_data_next  = out_data;
    out_pad_next   = out_pad;
    fifo_rd        = 1'b0;

    if (beat) out_valid_next = 1'b0;
    if (beat && !out_pad) count_next = (count == CNT_LAST) ? '0 : count + 1'b1;

    case (state)
      IDLE, BODY: begin
        if (beat && out_last) state_next = IDLE;
        // A word loaded in the same cycle as a TLAST beat opens the next
        // packet, so the load takes priority over returning to IDLE.
        if ((!out_valid || beat) && fifo_not_empty) begin
          fifo_rd        = 1'b1;
          out_valid_next = 1'b1;
          out_data_next  = fifo_data;
          out_pad_next   = 1'b0;
          state_next     = BODY;
        end
        if (state == BODY) begin
          if (!idle_cond) begin
            timer_next = '0;
          end else if ((TIMEOUT_CYCLES != 0) && (timer == TIMER_MAX)) begin
            // Output register is empty here, so the pad can load directly.
            state_next     = PAD;
            out_valid_next = 1'b1;
            out_data_next  = '1;
            out_pad_next   = 1'b1;
          end else if (timer != TIMER_MAX) begin
            timer_next = timer + 1'b1;
          end
        end
      end
      PAD: begin
        if (beat) begin
          count_next   = '0;
          timer_next   = '0;
          out_pad_next = 1'b0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state     <= IDLE;
      timer     <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '1;
      out_pad   <= 1'b0;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      count     <= count_next;
      out_valid <= out_valid_next;
      out_data  <= out_data_next;
      out_pad   <= out_pad_next;
    end
  end

  assign bus.MODULE_READY  = ready_q;
  assign bus.M_AXIS_TDATA  = out_data;
  assign bus.M_AXIS_TVALID = out_valid;
  assign bus.M_AXIS_TLAST  = out_last;
  assign bus.OVERFLOW      = overflow_q;
  assign bus.state         = state;
endmodule
